// File: rtl/button_debounce.sv
// button_debounce: per-key synchronizer, debouncer and press/release pulse generator
//
// Each of the N channels runs a two-flop synchronizer, a saturating debounce
// counter and a four-state FSM (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT).
//
// Ports:
//   clk    system clock, all state changes on its rising edge
//   reset  asynchronous, active-low reset
//   btn_n  [N] raw key pins, active-low (0 = pressed), asynchronous to clk
//   press  [N] one-cycle pulse per accepted press (and per auto-repeat)
//   rel    [N] one-cycle pulse per accepted release ("release" is a reserved word)
//   level  [N] debounced key state, 1 = held
//
// Compile-time option:
//   BUTTON_DEBOUNCE_REPEAT_EN  adds a per-channel auto-repeat timer that
//   re-issues press after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
module button_debounce #(
  parameter int N = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn_n,
  output logic [N-1:0] press,
  output logic [N-1:0] rel,
  output logic [N-1:0] level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  logic [N-1:0] sync_q, s;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync_q <= '0;
      s <= '0;
    end else begin
      sync_q <= ~btn_n;
      s <= sync_q;
    end
  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic press_d, rel_d, press_q, rel_q, rpt;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        state <= IDLE;
        cnt <= '0;
        press_q <= 1'b0;
        rel_q <= 1'b0;
      end else begin
        state <= state_d;
        cnt <= cnt_d;
        press_q <= press_d;
        rel_q <= rel_d;
      end
    // A change is accepted on the sample after the counter has reached
    // DEBOUNCE_CYCLES, so the pulse registers DEBOUNCE_CYCLES+2 edges after
    // the pin is first sampled.
    always_comb begin
      state_d = state;
      cnt_d = cnt;
      case (state)
        IDLE: if (s[i]) begin
          state_d = PRESS_WAIT;
          cnt_d = CW'(1);
        end
        PRESS_WAIT: begin
          state_d = !s[i] ? IDLE : cnt == CMAX ? HELD : PRESS_WAIT;
          cnt_d = !s[i] || cnt == CMAX ? '0 : cnt + CW'(1);
        end
        HELD: if (!s[i]) begin
          state_d = RELEASE_WAIT;
          cnt_d = CW'(1);
        end
        RELEASE_WAIT: begin
          state_d = s[i] ? HELD : cnt == CMAX ? IDLE : RELEASE_WAIT;
          cnt_d = s[i] || cnt == CMAX ? '0 : cnt + CW'(1);
        end
      endcase
    end
    always_comb begin
      press_d = (state == PRESS_WAIT && s[i] && cnt == CMAX) || rpt;
      rel_d = state == RELEASE_WAIT && !s[i] && cnt == CMAX;
    end
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW = $clog2(RMAX + 1);
    logic [TW-1:0] tmr, tmr_d;
    logic first, first_d, live;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        tmr <= '0;
        first <= 1'b1;
      end else begin
        tmr <= tmr_d;
        first <= first_d;
      end
    // The timer runs only while the key is logically held and not being
    // accepted as released this cycle, so repeat never collides with rel.
    // It sits at zero outside HELD/RELEASE_WAIT, which clears it on entry.
    always_comb begin
      live = (state == HELD || state == RELEASE_WAIT) && state_d != IDLE;
      rpt = live && tmr == (first ? TW'(REPEAT_DELAY - 1) : TW'(REPEAT_PERIOD - 1));
      tmr_d = !live || rpt ? '0 : tmr + TW'(1);
      first_d = !live ? 1'b1 : rpt ? 1'b0 : first;
    end
`else
    // The repeat parameters have no effect in this build; referencing them
    // keeps the parameter list identical in both builds.
    assign rpt = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif
    assign press[i] = press_q;
    assign rel[i] = rel_q;
    assign level[i] = state == HELD || state == RELEASE_WAIT;
  end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: self-checking bench for button_debounce
module tb_button_debounce;
  localparam int N = 3;
  localparam int D = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] btn_n = '1;
  logic [N-1:0] press, rel, level;
  int n_chk = 0;
  int n_fail = 0;
  bit run = 1'b0;

  button_debounce #(
    .N(N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_n(btn_n),
    .press(press),
    .rel(rel),
    .level(level)
  );

  always #5 clk = ~clk;

  // Reference model: a key is accepted as pressed once the last D+1
  // synchronized samples are all 1 while released, and as released once the
  // last D+1 samples are all 0 while held. Repeat pulses fall at RD, RD+RP, ...
  // cycles after the accepted press.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_press = '0, m_rel = '0, m_level = '0;
  logic [D:0] hist [N];
  int held [N];
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_s1 = '0;
      m_s2 = '0;
      m_press = '0;
      m_rel = '0;
      m_level = '0;
      for (int c = 0; c < N; c++) begin
        hist[c] = '0;
        held[c] = 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        hist[c] = {hist[c][D-1:0], m_s2[c]};
        m_press[c] = 1'b0;
        m_rel[c] = 1'b0;
        if (!m_level[c] && (&hist[c])) begin
          m_level[c] = 1'b1;
          m_press[c] = 1'b1;
          held[c] = 0;
        end else if (m_level[c] && !(|hist[c])) begin
          m_level[c] = 1'b0;
          m_rel[c] = 1'b1;
        end else if (m_level[c]) begin
          held[c]++;
          m_press[c] = REP && held[c] >= RD && (held[c] - RD) % RP == 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = ~btn_n;
    end

  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk)
    if (run) begin
      chk("model_press", press, m_press);
      chk("model_release", rel, m_rel);
      chk("model_level", level, m_level);
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("reset_press", press, 3'b000);
    chk("reset_release", rel, 3'b000);
    chk("reset_level", level, 3'b000);
    run = 1'b1;
    wait_n(3);
    reset = 1'b1;
    wait_n(2);
    // clean press on channel 0
    btn_n = 3'b110;
    wait_n(6);
    chk("clean_edge5", press, 3'b000);
    wait_n(1);
    chk("clean_press", press, 3'b001);
    chk("clean_level", level, 3'b001);
    wait_n(1);
    chk("clean_after", press, 3'b000);
    chk("clean_level_hold", level, 3'b001);
    wait_n(9);
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    chk("repeat_first", press, 3'b001);
    wait_n(3);
    chk("repeat_second", press, 3'b001);
`else
    chk("no_repeat_16", press, 3'b000);
    wait_n(3);
    chk("no_repeat_19", press, 3'b000);
`endif
    wait_n(1);
    // release with a one-sample glitch back to pressed
    btn_n = 3'b111;
    wait_n(2);
    btn_n = 3'b110;
    wait_n(1);
    btn_n = 3'b111;
    wait_n(6);
    chk("release_early", rel, 3'b000);
    chk("release_level_held", level, 3'b001);
    wait_n(1);
    chk("release_pulse", rel, 3'b001);
    chk("release_level", level, 3'b000);
    wait_n(1);
    chk("release_after", rel, 3'b000);
    // bounce on channel 1 never reaches acceptance
    wait_n(4);
    btn_n = 3'b101;
    wait_n(3);
    btn_n = 3'b111;
    wait_n(1);
    btn_n = 3'b101;
    wait_n(3);
    btn_n = 3'b111;
    wait_n(8);
    chk("bounce_level", level, 3'b000);
    // simultaneous press and release on all channels
    btn_n = 3'b000;
    wait_n(6);
    chk("simul_early", press, 3'b000);
    wait_n(1);
    chk("simul_press", press, 3'b111);
    chk("simul_level", level, 3'b111);
    btn_n = 3'b111;
    wait_n(7);
    chk("simul_release", rel, 3'b111);
    chk("simul_level_off", level, 3'b000);
    wait_n(4);
    // reset while ch0 is held and ch2 is mid-debounce
    btn_n = 3'b110;
    wait_n(7);
    chk("pre_reset_level", level, 3'b001);
    btn_n = 3'b010;
    wait_n(5);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_level", level, 3'b000);
    chk("async_reset_press", press, 3'b000);
    wait_n(2);
    reset = 1'b1;
    wait_n(6);
    chk("post_reset_early", press, 3'b000);
    wait_n(1);
    chk("post_reset_press", press, 3'b101);
    chk("post_reset_level", level, 3'b101);
    // long hold lets repeat pulses (if any) run under the model
    wait_n(30);
    btn_n = 3'b111;
    wait_n(10);
    chk("final_level", level, 3'b000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
